// File: rtl/bsg_pipe_skid_stage.sv
// Two-entry valid/ready skid stage; enqueued data appears on data_o the cycle after the edge.
// ready_o is a pure function of state and reset, so consumer stalls are absorbed by the skid slot.
module bsg_pipe_skid_stage #(
    parameter int width_p     = 8,
    parameter int ctr_width_p = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_o,
    output logic                   v_o,
    input  logic                   ready_i,
    output logic [1:0]             count_o,
    output logic [ctr_width_p-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam logic [ctr_width_p-1:0] ctr_one_lp = ctr_width_p'(1);

    state_e                 state_q, state_d;
    logic [width_p-1:0]     main_data_q, main_data_d;
    logic [width_p-1:0]     skid_data_q, skid_data_d;
    logic [ctr_width_p-1:0] stall_cnt_q, stall_cnt_d;
    logic                   enq, deq;

    assign ready_o     = ~reset & (state_q != FULL);
    assign v_o         = (state_q != EMPTY);
    assign data_o      = main_data_q;
    assign count_o     = state_q;
    assign stall_cnt_o = stall_cnt_q;

    assign enq = v_i & ready_o;
    assign deq = v_o & ready_i;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            EMPTY: begin
                if (enq) begin
                    main_data_d = data_i;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Streaming (enq & deq) refills main directly and leaves skid alone.
                if (enq && deq) begin
                    main_data_d = data_i;
                end else if (enq) begin
                    skid_data_d = data_i;
                    state_d     = FULL;
                end else if (deq) begin
                    state_d     = EMPTY;
                end
            end
            FULL: begin
                if (deq) begin
                    main_data_d = skid_data_q;
                    state_d     = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (v_o && !ready_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + ctr_one_lp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Skid contents are only observable after a FULL transition, so no reset is needed.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

endmodule

// File: tb/tb_bsg_pipe_skid_stage.sv
// Directed bench for bsg_pipe_skid_stage; a second instance with a 3-bit stall counter
// shares all inputs so counter saturation can be observed alongside the default build.
module tb_bsg_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_i;
    logic        v_i;
    logic        ready_i;
    logic        ready_o;
    logic [7:0]  data_o;
    logic        v_o;
    logic [1:0]  count_o;
    logic [15:0] stall_cnt_o;

    logic        s_ready_o;
    logic [7:0]  s_data_o;
    logic        s_v_o;
    logic [1:0]  s_count_o;
    logic [2:0]  s_stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bsg_pipe_skid_stage #(.width_p(8), .ctr_width_p(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .v_o         (v_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .stall_cnt_o (stall_cnt_o)
    );

    bsg_pipe_skid_stage #(.width_p(8), .ctr_width_p(3)) dut_small (
        .clk         (clk),
        .reset       (reset),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_o     (s_ready_o),
        .data_o      (s_data_o),
        .v_o         (s_v_o),
        .ready_i     (ready_i),
        .count_o     (s_count_o),
        .stall_cnt_o (s_stall_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; v_i = 1'b1; data_i = 8'h77; ready_i = 1'b0;
        tick(); tick();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got %b exp 0", v_o); end
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_held got %b exp 0", ready_o); end
        reset = 1'b0; v_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_release got %b exp 1", ready_o); end
        tick();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL idle_v_o got %b exp 0", v_o); end
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL idle_count got %0d exp 0", count_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL idle_stall got %0d exp 0", stall_cnt_o); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v_i = 1'b1; data_i = 8'(i);
            tick();
            checks++; if (v_o !== 1'b1 || data_o !== 8'(i)) begin errors++; $display("FAIL stream_data[%0d] got v=%b d=%h exp v=1 d=%h", i, v_o, data_o, 8'(i)); end
            checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count_o); end
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", i, ready_o); end
        end
        v_i = 1'b0;
        tick();
        checks++; if (count_o !== 2'd0 || v_o !== 1'b0) begin errors++; $display("FAIL stream_drain got count=%0d v=%b exp 0/0", count_o, v_o); end
        checks++; if (stall_cnt_o !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", stall_cnt_o); end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        v_i = 1'b1; data_i = 8'hA1; tick();
        v_i = 1'b1; data_i = 8'hA2; tick();
        v_i = 1'b1; data_i = 8'hA3;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", ready_o); end
        tick();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL bp_count got %0d exp 2", count_o); end
        checks++; if (v_o !== 1'b1 || data_o !== 8'hA1) begin errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=a1", v_o, data_o); end
        ready_i = 1'b1;
        tick();
        checks++; if (v_o !== 1'b1 || data_o !== 8'hA2) begin errors++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=a2", v_o, data_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL bp_count_after got %0d exp 1", count_o); end
        tick();
        checks++; if (v_o !== 1'b1 || data_o !== 8'hA3) begin errors++; $display("FAIL bp_third got v=%b d=%h exp v=1 d=a3", v_o, data_o); end
        v_i = 1'b0;
        tick();
        checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b exp 0", v_o); end
        checks++; if (stall_cnt_o !== 16'd2) begin errors++; $display("FAIL bp_stall got %0d exp 2", stall_cnt_o); end
    endtask

    task automatic test_full_dequeue();
        ready_i = 1'b0;
        v_i = 1'b1; data_i = 8'hB1; tick();
        v_i = 1'b1; data_i = 8'hB2; tick();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL fd_full got %0d exp 2", count_o); end
        v_i = 1'b0; ready_i = 1'b1;
        tick();
        checks++; if (v_o !== 1'b1 || data_o !== 8'hB2) begin errors++; $display("FAIL fd_data got v=%b d=%h exp v=1 d=b2", v_o, data_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL fd_count got %0d exp 1", count_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL fd_ready got %b exp 1", ready_o); end
        tick();
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL fd_drain got %0d exp 0", count_o); end
        checks++; if (stall_cnt_o !== 16'd3) begin errors++; $display("FAIL fd_stall got %0d exp 3", stall_cnt_o); end
    endtask

    task automatic test_saturation();
        reset = 1'b1; v_i = 1'b0; ready_i = 1'b0;
        tick();
        reset = 1'b0;
        v_i = 1'b1; data_i = 8'hC1; tick();
        v_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                checks++; if (s_stall_cnt_o !== 3'd5) begin errors++; $display("FAIL sat_mid got %0d exp 5", s_stall_cnt_o); end
            end
        end
        checks++; if (s_stall_cnt_o !== 3'd7) begin errors++; $display("FAIL sat_small got %0d exp 7", s_stall_cnt_o); end
        checks++; if (stall_cnt_o !== 16'd10) begin errors++; $display("FAIL sat_wide got %0d exp 10", stall_cnt_o); end
        checks++; if (s_v_o !== 1'b1 || s_data_o !== 8'hC1) begin errors++; $display("FAIL sat_head got v=%b d=%h exp v=1 d=c1", s_v_o, s_data_o); end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b0;
        v_i = 1'b1; data_i = 8'hD1; tick();
        v_i = 1'b1; data_i = 8'hD2; tick();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL mr_full got %0d exp 2", count_o); end
        reset = 1'b1; ready_i = 1'b1; v_i = 1'b0;
        tick();
        reset = 1'b0; ready_i = 1'b0;
        #1;
        checks++; if (v_o !== 1'b0 || count_o !== 2'd0) begin errors++; $display("FAIL mr_clear got v=%b count=%0d exp 0/0", v_o, count_o); end
        checks++; if (stall_cnt_o !== 16'd0 || s_stall_cnt_o !== 3'd0) begin errors++; $display("FAIL mr_stall got %0d/%0d exp 0/0", stall_cnt_o, s_stall_cnt_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL mr_ready got %b exp 1", ready_o); end
        v_i = 1'b1; data_i = 8'h5A;
        tick();
        v_i = 1'b0;
        checks++; if (v_o !== 1'b1 || data_o !== 8'h5A) begin errors++; $display("FAIL mr_push got v=%b d=%h exp v=1 d=5a", v_o, data_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL mr_count got %0d exp 1", count_o); end
    endtask

    initial begin
        reset = 1'b1; v_i = 1'b0; data_i = 8'h00; ready_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_dequeue();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
